// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit registered multiplexer with manual select and
// auto-scan modes; out-of-range channel numbers drive the DEFAULT word.
//
// Ports:
//   clock   - rising-edge system clock
//   resetn  - asynchronous active-low reset
//   mux_in  - N packed channels, channel c at [c*W +: W]
//   sel     - channel number loaded in manual mode when load=1
//   load    - manual mode: load sel into the channel register
//   mode    - 0 = manual, 1 = auto-scan
//   out     - registered data of the current channel
//   ch_out  - current channel register
//   step    - one-cycle pulse after the channel register changes
module scan_mux #(
    parameter int              N       = 7,
    parameter int              W       = 1,
    parameter int              SEL_W   = 3,
    parameter int              PERIOD  = 4,
    parameter logic [W-1:0]    DEFAULT = '0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [N*W-1:0]     mux_in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    input  logic               mode,
    output logic [W-1:0]       out,
    output logic [SEL_W-1:0]   ch_out,
    output logic               step
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic [W-1:0]     out_q, out_d;
    logic             step_q, step_d;
    logic             mode_q, mode_d;

    always_comb begin
        // First scan cycle after manual starts the dwell from zero.
        cnt_base = mode_q ? cnt_q : '0;
        ch_d     = ch_q;
        cnt_d    = '0;
        mode_d   = mode;

        if (mode) begin
            if (cnt_base == CNT_LAST) begin
                cnt_d = '0;
                // Last channel and any out-of-range channel wrap to 0.
                ch_d  = (ch_q >= CH_LAST) ? '0 : ch_q + 1'b1;
            end else begin
                cnt_d = cnt_base + CNT_W'(1);
            end
        end else if (load) begin
            ch_d = sel;
        end

        step_d = (ch_d != ch_q);

        out_d = DEFAULT;
        for (int c = 0; c < N; c++) begin
            if (ch_q == SEL_W'(c)) begin
                out_d = mux_in[c*W +: W];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ch_q   <= '0;
            cnt_q  <= '0;
            out_q  <= DEFAULT;
            step_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            ch_q   <= ch_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    assign out    = out_q;
    assign ch_out = ch_q;
    assign step   = step_q;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed bench for scan_mux, a 7x1 PERIOD=4 instance and a
// 4x4 PERIOD=1 instance sharing clock and reset.
module tb_scan_mux;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic [6:0] mux_a;
    logic [2:0] sel_a;
    logic       load_a, mode_a;
    logic       out_a, step_a;
    logic [2:0] ch_a;

    logic [15:0] mux_b;
    logic [1:0]  sel_b;
    logic        load_b, mode_b;
    logic [3:0]  out_b;
    logic [1:0]  ch_b;
    logic        step_b;

    scan_mux #(
        .N(7), .W(1), .SEL_W(3), .PERIOD(4), .DEFAULT(1'b0)
    ) u_a (
        .clock(clock), .resetn(resetn), .mux_in(mux_a), .sel(sel_a),
        .load(load_a), .mode(mode_a), .out(out_a), .ch_out(ch_a),
        .step(step_a)
    );

    scan_mux #(
        .N(4), .W(4), .SEL_W(2), .PERIOD(1), .DEFAULT(4'h0)
    ) u_b (
        .clock(clock), .resetn(resetn), .mux_in(mux_b), .sel(sel_b),
        .load(load_b), .mode(mode_b), .out(out_b), .ch_out(ch_b),
        .step(step_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic       load;
        logic [2:0] sel;
        logic [6:0] mux;
        logic [2:0] ch;
        logic       out;
        logic       step;
    } vec_t;

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 3'd3, 7'h08, 3'd3, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 7'h08, 3'd3, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 3'd2, 7'h08, 3'd2, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 3'd0, 7'h08, 3'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'd2, 7'h08, 3'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'd7, 7'h7F, 3'd7, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 3'd0, 7'h7F, 3'd7, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 7'h7F, 3'd7, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 7'h7F, 3'd7, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 7'h7F, 3'd7, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 7'h7F, 3'd0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 7'h7F, 3'd0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 3'd0, 7'h02, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 3'd5, 7'h02, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 3'd0, 7'h02, 3'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 3'd0, 7'h02, 3'd0, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 3'd0, 7'h02, 3'd1, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 3'd0, 7'h02, 3'd1, 1'b1, 1'b0};

        resetn = 1'b0;
        mux_a  = 7'h7F;
        sel_a  = 3'd0;
        load_a = 1'b0;
        mode_a = 1'b0;
        mux_b  = 16'hDCBA;
        sel_b  = 2'd0;
        load_b = 1'b0;
        mode_b = 1'b1;

        // Held in reset across edges.
        tick();
        tick();
        check("rst_out", 32'(out_a), 32'd0);
        check("rst_ch", 32'(ch_a), 32'd0);
        check("rst_step", 32'(step_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);

        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Manual select, out-of-range, mode switch, mode-vs-load.
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            mode_a = tbl[i].mode;
            load_a = tbl[i].load;
            sel_a  = tbl[i].sel;
            mux_a  = tbl[i].mux;
            tick();
            check($sformatf("v%0d_ch", i), 32'(ch_a), 32'(tbl[i].ch));
            check($sformatf("v%0d_out", i), 32'(out_a), 32'(tbl[i].out));
            check($sformatf("v%0d_step", i), 32'(step_a),
                  32'(tbl[i].step));
        end

        // Full revolution from reset in scan mode, both instances.
        @(negedge clock);
        resetn = 1'b0;
        mode_a = 1'b1;
        load_a = 1'b0;
        mux_a  = 7'b1010101;
        @(negedge clock);
        resetn = 1'b1;
        begin
            int steps;
            steps = 0;
            for (int k = 1; k <= 28; k++) begin
                tick();
                if (step_a) steps++;
                check($sformatf("rev%0d_ch", k), 32'(ch_a),
                      32'((k / 4) % 7));
                check($sformatf("rev%0d_out", k), 32'(out_a),
                      32'(mux_a[((k - 1) / 4) % 7]));
                check($sformatf("rev%0d_step", k), 32'(step_a),
                      32'(k % 4 == 0));
                check($sformatf("wide%0d_ch", k), 32'(ch_b),
                      32'(k % 4));
                check($sformatf("wide%0d_out", k), 32'(out_b),
                      32'(4'hA + 4'((k - 1) % 4)));
                check($sformatf("wide%0d_step", k), 32'(step_b), 32'd1);
            end
            check("rev_steps", 32'(steps), 32'd7);
        end

        // Mid-dwell asynchronous reset at ch=4, cnt=2.
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 1; k <= 18; k++) tick();
        check("mid_ch", 32'(ch_a), 32'd4);
        check("mid_out", 32'(out_a), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_ch", 32'(ch_a), 32'd0);
        check("async_out", 32'(out_a), 32'd0);
        check("async_step", 32'(step_a), 32'd0);
        check("async_out_b", 32'(out_b), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("restart%0d_ch", k), 32'(ch_a),
                  32'(k == 4));
            check($sformatf("restart%0d_step", k), 32'(step_a),
                  32'(k == 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
